// File: rtl/msdf_online_ctrl_if.sv
// Handshake and strobe bundle between an MSDF online sequencing controller
// and its client (operand sources plus online datapath levels).
interface msdf_online_ctrl_if #(
  parameter int unsigned LEVELS = 3,
  parameter int unsigned CW     = 8
) ();

  logic              start;
  logic              stall;
  logic              busy;
  logic [LEVELS-1:0] load_level;
  logic              in_valid;
  logic              in_first;
  logic              in_last;
  logic              ready_zj;
  logic              out_first;
  logic              out_last;
  logic [CW-1:0]     digit_idx;
  logic              done;

  // Client side: requests operations and applies back-pressure.
  modport master (
    output start, stall,
    input  busy, load_level, in_valid, in_first, in_last,
    input  ready_zj, out_first, out_last, digit_idx, done
  );

  // Controller side.
  modport slave (
    input  start, stall,
    output busy, load_level, in_valid, in_first, in_last,
    output ready_zj, out_first, out_last, digit_idx, done
  );

endinterface

// File: rtl/msdf_online_ctrl.sv
// Sequencing controller for MSDF online serial arithmetic. One N-digit
// operation per start; emits input-accept, output-valid and per-level load
// strobes offset by the online delay DELTA. Strobes are pure decodes of the
// registered state, the step counter and stall.
module msdf_online_ctrl #(
  parameter int unsigned N      = 9,
  parameter int unsigned DELTA  = 2,
  parameter int unsigned LEVELS = 3,
  parameter int unsigned CW     = 8
) (
  input logic                clk,
  input logic                rst,
  msdf_online_ctrl_if.slave  ctrl_io
);

  if (LEVELS < 1 || LEVELS > DELTA + 1) begin : g_bad_levels
    $error("msdf_online_ctrl: LEVELS must satisfy 1 <= LEVELS <= DELTA+1");
  end
  if ((64'd1 << CW) <= 64'(N + DELTA)) begin : g_bad_cw
    $error("msdf_online_ctrl: CW too narrow, need 2^CW > N+DELTA");
  end

  localparam logic [CW-1:0] LastCnt  = CW'(N + DELTA - 1);
  localparam logic [CW-1:0] LastIn   = CW'(N - 1);
  localparam logic [CW-1:0] NumDig   = CW'(N);
  localparam logic [CW-1:0] FirstOut = CW'(DELTA);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic              active;
  logic              busy;
  logic [LEVELS-1:0] load_level;
  logic              in_valid, in_first, in_last;
  logic              ready_zj, out_first, out_last;
  logic              done;
  logic [CW-1:0]     digit_idx;

  // State and step counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: start only matters in IDLE/DONE; stall freezes the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (ctrl_io.start) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (!ctrl_io.stall) begin
          if (cnt_q == LastCnt) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (ctrl_io.start) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobe decodes. A window [lo, lo+N-1] is tested as (cnt - lo) < N: when
  // cnt < lo the subtraction wraps to >= 2^CW - DELTA, which exceeds N-1
  // because 2^CW > N+DELTA.
  always_comb begin
    active     = (state_q == StRun) && !ctrl_io.stall;
    busy       = (state_q == StRun);
    done       = (state_q == StDone);
    digit_idx  = busy ? cnt_q : '0;
    in_valid   = active && (cnt_q < NumDig);
    in_first   = active && (cnt_q == '0);
    in_last    = active && (cnt_q == LastIn);
    ready_zj   = active && ((cnt_q - FirstOut) < NumDig);
    out_first  = active && (cnt_q == FirstOut);
    out_last   = active && (cnt_q == LastCnt);
    load_level = '0;
    for (int k = 0; k < int'(LEVELS); k++) begin
      load_level[k] = active && ((cnt_q - CW'(k)) < NumDig);
    end
  end

  assign ctrl_io.busy       = busy;
  assign ctrl_io.load_level = load_level;
  assign ctrl_io.in_valid   = in_valid;
  assign ctrl_io.in_first   = in_first;
  assign ctrl_io.in_last    = in_last;
  assign ctrl_io.ready_zj   = ready_zj;
  assign ctrl_io.out_first  = out_first;
  assign ctrl_io.out_last   = out_last;
  assign ctrl_io.digit_idx  = digit_idx;
  assign ctrl_io.done       = done;

endmodule

// File: tb/tb_msdf_online_ctrl.sv
// Scoreboard bench for msdf_online_ctrl: default instance (N=9, DELTA=2,
// LEVELS=3) and a second instance (N=4, DELTA=3, LEVELS=4). Stimulus pushes
// the expected per-cycle outputs; a negedge monitor pops and compares.
module tb_msdf_online_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  msdf_online_ctrl_if #(.LEVELS(3), .CW(8)) ifa ();
  msdf_online_ctrl_if #(.LEVELS(4), .CW(8)) ifb ();

  msdf_online_ctrl #(.N(9), .DELTA(2), .LEVELS(3), .CW(8)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (ifa)
  );

  msdf_online_ctrl #(.N(4), .DELTA(3), .LEVELS(4), .CW(8)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (ifb)
  );

  typedef struct packed {
    logic       busy;
    logic [3:0] ll;
    logic       iv;
    logic       ifst;
    logic       ilst;
    logic       rz;
    logic       of;
    logic       ol;
    logic [7:0] idx;
    logic       done;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  obs_t act_a, act_b;
  assign act_a = {ifa.busy, 1'b0, ifa.load_level, ifa.in_valid, ifa.in_first, ifa.in_last,
                  ifa.ready_zj, ifa.out_first, ifa.out_last, ifa.digit_idx, ifa.done};
  assign act_b = {ifb.busy, ifb.load_level, ifb.in_valid, ifb.in_first, ifb.in_last,
                  ifb.ready_zj, ifb.out_first, ifb.out_last, ifb.digit_idx, ifb.done};

  int n_total = 0;
  int n_pass  = 0;
  int iv_a = 0, rz_a = 0, busy_a = 0, done_a = 0;

  task automatic check_obs(input string nm, input int c, input obs_t act, input obs_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Expected outputs for a RUN cycle with counter c (s = stalled).
  function automatic obs_t exp_run(input int c, input bit s, input int n, input int d,
                                   input int l);
    obs_t o = '0;
    o.busy = 1'b1;
    o.idx  = 8'(c);
    if (!s) begin
      o.iv   = (c < n);
      o.ifst = (c == 0);
      o.ilst = (c == n - 1);
      o.rz   = (c >= d) && (c <= n + d - 1);
      o.of   = (c == d);
      o.ol   = (c == n + d - 1);
      for (int k = 0; k < l; k++) o.ll[k] = (c >= k) && (c <= n - 1 + k);
    end
    return o;
  endfunction

  task automatic push(input bit which, input int t, input obs_t o);
    exp_t e;
    e.cyc = t;
    e.o   = o;
    if (which) qb.push_back(e);
    else qa.push_back(e);
  endtask

  // Schedule one operation starting (cnt=0) at cycle t0. abort_at >= 0 stops
  // after that count with no done record; t_done is the last scheduled cycle.
  task automatic push_op(input bit which, input int t0, input int n, input int d, input int l,
                         input int stall_at, input int stall_len, input int abort_at,
                         output int t_done);
    obs_t o;
    int t = t0;
    for (int c = 0; c <= n + d - 1; c++) begin
      if (c == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          push(which, t, exp_run(c, 1'b1, n, d, l));
          t++;
        end
      end
      push(which, t, exp_run(c, 1'b0, n, d, l));
      t++;
      if (c == abort_at) begin
        t_done = t - 1;
        return;
      end
    end
    o = '0;
    o.done = 1'b1;
    push(which, t, o);
    t_done = t;
  endtask

  // Monitor: a scheduled record is compared on its cycle, otherwise idle zeros.
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0 && qa[0].cyc == cyc) begin
      e = qa.pop_front();
      check_obs("a_obs", cyc, act_a, e.o);
    end else begin
      check_obs("a_idle", cyc, act_a, '0);
    end
    if (qb.size() > 0 && qb[0].cyc == cyc) begin
      e = qb.pop_front();
      check_obs("b_obs", cyc, act_b, e.o);
    end else begin
      check_obs("b_idle", cyc, act_b, '0);
    end
    if (act_a.iv)   iv_a++;
    if (act_a.rz)   rz_a++;
    if (act_a.busy) busy_a++;
    if (act_a.done) done_a++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    iv_a = 0; rz_a = 0; busy_a = 0; done_a = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int td, td2;
    rst = 1'b1;
    ifa.start = 1'b0; ifa.stall = 1'b0;
    ifb.start = 1'b0; ifb.stall = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Quiet IDLE for 20 cycles.
    clr_counts();
    repeat (20) tick();
    check_int("idle_busy", busy_a, 0);

    // Plain operation.
    clr_counts();
    ifa.start = 1'b1;
    push_op(1'b0, cyc + 1, 9, 2, 3, -1, 0, -1, td);
    tick();
    ifa.start = 1'b0;
    while (cyc <= td) tick();
    check_int("op1_in_valid", iv_a, 9);
    check_int("op1_ready_zj", rz_a, 9);
    check_int("op1_busy", busy_a, 11);
    check_int("op1_done", done_a, 1);

    // Stall at cnt=3 for two cycles.
    clr_counts();
    ifa.start = 1'b1;
    push_op(1'b0, cyc + 1, 9, 2, 3, 3, 2, -1, td);
    tick();
    ifa.start = 1'b0;
    repeat (3) tick();
    ifa.stall = 1'b1;
    repeat (2) tick();
    ifa.stall = 1'b0;
    while (cyc <= td) tick();
    check_int("stall_in_valid", iv_a, 9);
    check_int("stall_ready_zj", rz_a, 9);
    check_int("stall_busy", busy_a, 13);

    // start held high: back-to-back operations with no IDLE gap.
    clr_counts();
    ifa.start = 1'b1;
    push_op(1'b0, cyc + 1, 9, 2, 3, -1, 0, -1, td);
    push_op(1'b0, td + 1, 9, 2, 3, -1, 0, -1, td2);
    while (cyc < td2) tick();
    ifa.start = 1'b0;
    tick();
    check_int("b2b_in_valid", iv_a, 18);
    check_int("b2b_busy", busy_a, 22);
    check_int("b2b_done", done_a, 2);

    // Reset at cnt=5 aborts without done; then a clean operation.
    clr_counts();
    ifa.start = 1'b1;
    push_op(1'b0, cyc + 1, 9, 2, 3, -1, 0, 5, td);
    tick();
    ifa.start = 1'b0;
    while (cyc < td) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check_int("abort_done", done_a, 0);
    check_int("abort_busy", busy_a, 6);
    clr_counts();
    ifa.start = 1'b1;
    push_op(1'b0, cyc + 1, 9, 2, 3, -1, 0, -1, td);
    tick();
    ifa.start = 1'b0;
    while (cyc <= td) tick();
    check_int("post_rst_busy", busy_a, 11);
    check_int("post_rst_done", done_a, 1);

    // Second configuration: N=4, DELTA=3, LEVELS=4 -> 7 RUN cycles.
    ifb.start = 1'b1;
    push_op(1'b1, cyc + 1, 4, 3, 4, -1, 0, -1, td);
    tick();
    ifb.start = 1'b0;
    while (cyc <= td) tick();

    repeat (3) tick();
    check_int("qa_drained", qa.size(), 0);
    check_int("qb_drained", qb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
